// File: rtl/conv_window_fetch_if.sv
// Bundles the nine-port arbiter bus and the window valid/ready stream.
// The master side is the window fetcher; the slave side is the arbiter plus consumer.
interface conv_window_fetch_if #(
   parameter int ADDR_WIDTH    = 16,
   parameter int DATABUS_WIDTH = 32,
   parameter int DIM_WIDTH     = 8
);
   logic [8:0]                     mem_w_ind;
   logic [8:0]                     mem_sel_ind;
   logic [8:0]                     mem_ready_ind;
   logic [8:0][ADDR_WIDTH-1:0]     addr_bus_ind;
   logic [8:0][DATABUS_WIDTH-1:0]  data_bus_ind;
   logic                           win_valid;
   logic                           win_ready;
   logic [8:0][DATABUS_WIDTH-1:0]  win_data;
   logic [DIM_WIDTH-1:0]           win_row;
   logic [DIM_WIDTH-1:0]           win_col;

   modport master (
      output mem_w_ind, mem_sel_ind, addr_bus_ind,
      input  mem_ready_ind, data_bus_ind,
      output win_valid, win_data, win_row, win_col,
      input  win_ready
   );

   modport slave (
      input  mem_w_ind, mem_sel_ind, addr_bus_ind,
      output mem_ready_ind, data_bus_ind,
      input  win_valid, win_data, win_row, win_col,
      output win_ready
   );
endinterface

// File: rtl/conv_window_fetch.sv
// 3x3 window fetcher: walks a row-major feature map, issues one read per tap
// on its own arbiter port, gathers the nine words and hands the window on.
module conv_window_fetch #(
   parameter int ADDR_WIDTH    = 16,
   parameter int DATABUS_WIDTH = 32,
   parameter int DIM_WIDTH     = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [DIM_WIDTH-1:0]  img_width,
   input  logic [DIM_WIDTH-1:0]  img_height,
   output logic                  busy,
   output logic                  done,
   conv_window_fetch_if.master   bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_GATHER,
      S_OUT,
      S_DONE
   } state_t;

   state_t                         state;
   logic [ADDR_WIDTH-1:0]          base_q;
   logic [DIM_WIDTH-1:0]           width_q;
   logic [DIM_WIDTH-1:0]           height_q;
   logic [DIM_WIDTH-1:0]           row_q;
   logic [DIM_WIDTH-1:0]           col_q;
   logic [8:0]                     sel_q;
   logic [8:0]                     mask_q;
   logic [8:0][ADDR_WIDTH-1:0]     addr_q;
   logic [8:0][DATABUS_WIDTH-1:0]  data_q;
   logic                           valid_q;
   logic                           busy_q;
   logic                           done_q;

   logic [8:0]                     hit;
   logic [8:0]                     mask_next;
   logic [8:0][ADDR_WIDTH-1:0]     tap_addr;
   logic                           last_col;
   logic                           last_row;

   // A tap completes only when the arbiter answers a port we are requesting on.
   assign hit       = sel_q & bus.mem_ready_ind;
   assign mask_next = mask_q | hit;
   assign last_col  = (col_q == width_q - DIM_WIDTH'(3));
   assign last_row  = (row_q == height_q - DIM_WIDTH'(3));

   // Tap addresses of the current window, wrapping mod 2^ADDR_WIDTH.
   always_comb begin
      // NOTE: default first so every path assigns every bit and no latch is inferred.
      tap_addr = '0;
      for (int dy = 0; dy < 3; dy++) begin
         for (int dx = 0; dx < 3; dx++) begin
            tap_addr[dy*3+dx] = base_q
                              + (ADDR_WIDTH'(row_q) + ADDR_WIDTH'(dy)) * ADDR_WIDTH'(width_q)
                              + ADDR_WIDTH'(col_q) + ADDR_WIDTH'(dx);
         end
      end
   end

   // Frame walker: issue, gather, present, advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         base_q   <= '0;
         width_q  <= '0;
         height_q <= '0;
         row_q    <= '0;
         col_q    <= '0;
         sel_q    <= '0;
         mask_q   <= '0;
         addr_q   <= '0;
         // NOTE: the window bank is reset because it is visible on the port straight out of reset.
         data_q   <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register sees pre-edge values.
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  base_q   <= base_addr;
                  width_q  <= img_width;
                  height_q <= img_height;
                  row_q    <= '0;
                  col_q    <= '0;
                  busy_q   <= 1'b1;
                  if (img_width < DIM_WIDTH'(3) || img_height < DIM_WIDTH'(3))
                     state <= S_DONE;
                  else
                     state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               addr_q <= tap_addr;
               mask_q <= '0;
               // A port whose ready is still high from the last window waits before re-requesting.
               sel_q  <= ~bus.mem_ready_ind;
               state  <= S_GATHER;
            end
            S_GATHER: begin
               for (int k = 0; k < 9; k++) begin
                  if (hit[k])
                     data_q[k] <= bus.data_bus_ind[k];
               end
               sel_q  <= (sel_q & ~hit) | (~mask_next & ~sel_q & ~bus.mem_ready_ind);
               mask_q <= mask_next;
               if (&mask_next) begin
                  valid_q <= 1'b1;
                  state   <= S_OUT;
               end
            end
            S_OUT: begin
               if (bus.win_ready) begin
                  valid_q <= 1'b0;
                  if (last_col && last_row) begin
                     state <= S_DONE;
                  end else begin
                     state <= S_ISSUE;
                     if (last_col) begin
                        col_q <= '0;
                        row_q <= row_q + DIM_WIDTH'(1);
                     end else begin
                        col_q <= col_q + DIM_WIDTH'(1);
                     end
                  end
               end
            end
            S_DONE: begin
               done_q <= 1'b1;
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy             = busy_q;
   assign done             = done_q;
   assign bus.mem_w_ind    = '0;
   assign bus.mem_sel_ind  = sel_q;
   assign bus.addr_bus_ind = addr_q;
   assign bus.win_valid    = valid_q;
   assign bus.win_data     = data_q;
   assign bus.win_row      = row_q;
   assign bus.win_col      = col_q;

endmodule

// File: tb/tb_conv_window_fetch.sv
// Bench for conv_window_fetch: memory/arbiter model, window scoreboard and scenario tasks.
module tb_conv_window_fetch;

   localparam int AW  = 16;
   localparam int DBW = 32;
   localparam int DMW = 8;

   typedef struct {
      logic [DMW-1:0]       row;
      logic [DMW-1:0]       col;
      logic [8:0][AW-1:0]   addr;
      logic [8:0][DBW-1:0]  data;
   } win_t;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start;
   logic [AW-1:0]  base_addr;
   logic [DMW-1:0] img_width;
   logic [DMW-1:0] img_height;
   logic           busy;
   logic           done;

   conv_window_fetch_if #(.ADDR_WIDTH(AW), .DATABUS_WIDTH(DBW), .DIM_WIDTH(DMW)) bus ();

   conv_window_fetch #(.ADDR_WIDTH(AW), .DATABUS_WIDTH(DBW), .DIM_WIDTH(DMW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .base_addr  (base_addr),
      .img_width  (img_width),
      .img_height (img_height),
      .busy       (busy),
      .done       (done),
      .bus        (bus.master)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   win_t       exp_q[$];
   win_t       cur;
   logic [8:0] script_q[$];
   int         arb_mode = 0;   // 0: round-robin, one port per cycle; 1: scripted masks
   int         rr_ptr   = 0;
   int         grant_k;
   logic [8:0] arb_next;
   int         done_cnt = 0;
   logic       done_prev = 1'b0;
   logic       sel_seen = 1'b0;

   function automatic logic [DBW-1:0] mem_f(input logic [AW-1:0] a);
      return {a ^ 16'hC3A5, a};
   endfunction

   for (genvar g = 0; g < 9; g++) begin : g_mem
      assign bus.data_bus_ind[g] = mem_f(bus.addr_bus_ind[g]);
   end

   // Expected windows of a whole frame, in walk order.
   task automatic push_frame(input logic [AW-1:0] b, input int w, input int h);
      win_t e;
      logic [AW-1:0] a;
      if (w < 3 || h < 3) return;
      for (int r = 0; r <= h - 3; r++) begin
         for (int c = 0; c <= w - 3; c++) begin
            e.row = DMW'(r);
            e.col = DMW'(c);
            for (int k = 0; k < 9; k++) begin
               a = b + AW'((r + k / 3) * w) + AW'(c + k % 3);
               e.addr[k] = a;
               e.data[k] = mem_f(a);
            end
            exp_q.push_back(e);
         end
      end
   endtask

   // Arbiter model, scoreboard and done monitor, all sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         bus.mem_ready_ind = '0;
         done_prev = 1'b0;
      end else begin
         if (bus.mem_sel_ind != 9'h000) sel_seen = 1'b1;
         if (bus.win_valid && bus.win_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL win_unexpected got row %0d col %0d required no window", bus.win_row, bus.win_col);
            end else begin
               cur = exp_q.pop_front();
               if (bus.win_row !== cur.row || bus.win_col !== cur.col) begin
                  n_err++;
                  $display("FAIL win_pos got (%0d,%0d) required (%0d,%0d)", bus.win_row, bus.win_col, cur.row, cur.col);
               end
               n_vec++;
               if (bus.win_data !== cur.data) begin
                  n_err++;
                  $display("FAIL win_data at (%0d,%0d) got %h required %h", cur.row, cur.col, bus.win_data, cur.data);
               end
            end
         end
         if (done) begin
            done_cnt++;
            n_vec++;
            if (busy !== 1'b0 || done_prev) begin
               n_err++;
               $display("FAIL done_pulse got busy %b prev_done %b required busy 0 prev_done 0", busy, done_prev);
            end
         end
         done_prev = done;

         arb_next = '0;
         if (arb_mode == 0) begin
            for (int i = 0; i < 9; i++) begin
               if (arb_next == 9'h000 && bus.mem_sel_ind[(rr_ptr + i) % 9]) begin
                  arb_next[(rr_ptr + i) % 9] = 1'b1;
                  grant_k = (rr_ptr + i) % 9;
               end
            end
            if (arb_next != 9'h000) rr_ptr = (grant_k + 1) % 9;
         end else if (bus.mem_sel_ind != 9'h000 && script_q.size() > 0) begin
            arb_next = script_q.pop_front();
         end
         if ((arb_next & bus.mem_sel_ind) != 9'h000) begin
            n_vec++;
            if (bus.mem_w_ind !== 9'h000) begin
               n_err++;
               $display("FAIL mem_w got %h required 000", bus.mem_w_ind);
            end
         end
         for (int k = 0; k < 9; k++) begin
            if (arb_next[k] && bus.mem_sel_ind[k]) begin
               n_vec++;
               if (exp_q.size() == 0) begin
                  n_err++;
                  $display("FAIL addr_tap%0d got %h required no request", k, bus.addr_bus_ind[k]);
               end else if (bus.addr_bus_ind[k] !== exp_q[0].addr[k]) begin
                  n_err++;
                  $display("FAIL addr_tap%0d got %h required %h", k, bus.addr_bus_ind[k], exp_q[0].addr[k]);
               end
            end
         end
         bus.mem_ready_ind = arb_next;
      end
   end

   task automatic do_start(input logic [AW-1:0] b, input int w, input int h, input bit push);
      if (push) push_frame(b, w, h);
      @(posedge clk); #1;
      base_addr  = b;
      img_width  = DMW'(w);
      img_height = DMW'(h);
      start      = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
   endtask

   task automatic wait_done(input string name, input int bound);
      int c0 = done_cnt;
      int n  = 0;
      while (done_cnt == c0 && n < bound) begin
         @(posedge clk); #1;
         n++;
      end
      n_vec++;
      if (done_cnt == c0) begin
         n_err++;
         $display("FAIL %s_timeout got no done within %0d cycles required done", name, bound);
      end
   endtask

   task automatic check_frame_end(input string name, input int cnt0);
      n_vec++;
      if (exp_q.size() != 0 || done_cnt != cnt0 + 1) begin
         n_err++;
         $display("FAIL %s_end got %0d windows left, %0d dones required 0 left, 1 done", name, exp_q.size(), done_cnt - cnt0);
      end
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int pass = 0; pass < 2; pass++) begin
         n_vec++;
         if (busy !== 1'b0 || done !== 1'b0 || bus.mem_sel_ind !== 9'h000 || bus.mem_w_ind !== 9'h000) begin
            n_err++;
            $display("FAIL reset_ctrl%0d got busy %b done %b sel %h w %h required 0 0 000 000", pass, busy, done, bus.mem_sel_ind, bus.mem_w_ind);
         end
         n_vec++;
         if (bus.addr_bus_ind !== '0 || bus.win_valid !== 1'b0 || bus.win_data !== '0 || bus.win_row !== '0 || bus.win_col !== '0) begin
            n_err++;
            $display("FAIL reset_win%0d got valid %b row %0d col %0d required all zero", pass, bus.win_valid, bus.win_row, bus.win_col);
         end
         if (pass == 0) begin
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_basic();
      logic [AW-1:0] first_addr[9] = '{16'h0100, 16'h0101, 16'h0102, 16'h0104, 16'h0105,
                                       16'h0106, 16'h0108, 16'h0109, 16'h010A};
      int c0 = done_cnt;
      arb_mode = 0;
      do_start(16'h0100, 4, 4, 1'b1);
      @(posedge clk); #1;
      n_vec++;
      if (bus.mem_sel_ind !== 9'h1FF) begin
         n_err++;
         $display("FAIL basic_sel_rise got %h required 1ff", bus.mem_sel_ind);
      end
      for (int k = 0; k < 9; k++) begin
         n_vec++;
         if (bus.addr_bus_ind[k] !== first_addr[k]) begin
            n_err++;
            $display("FAIL basic_addr%0d got %h required %h", k, bus.addr_bus_ind[k], first_addr[k]);
         end
      end
      wait_done("basic", 400);
      check_frame_end("basic", c0);
   endtask

   task automatic test_out_of_order();
      logic [8:0] script[7] = '{9'h111, 9'h080, 9'h040, 9'h020, 9'h008, 9'h004, 9'h002};
      logic [8:0] cum = '0;
      int c0 = done_cnt;
      int n  = 0;
      arb_mode = 1;
      for (int i = 0; i < 7; i++) script_q.push_back(script[i]);
      do_start(16'h2000, 3, 3, 1'b1);
      while (bus.mem_sel_ind == 9'h000 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      for (int i = 0; i < 7; i++) begin
         @(posedge clk); #1;
         cum = cum | script[i];
         n_vec++;
         if (bus.mem_sel_ind !== ~cum || bus.win_valid !== (i == 6)) begin
            n_err++;
            $display("FAIL ooo_step%0d got sel %h valid %b required sel %h valid %b", i, bus.mem_sel_ind, bus.win_valid, ~cum, i == 6);
         end
      end
      wait_done("ooo", 100);
      check_frame_end("ooo", c0);
      script_q.delete();
      arb_mode = 0;
   endtask

   task automatic test_backpressure();
      int c0 = done_cnt;
      int n  = 0;
      bus.win_ready = 1'b0;
      do_start(16'h0400, 4, 3, 1'b1);
      while (bus.win_valid !== 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL bp_hold%0d got empty scoreboard required pending window", i);
         end else if (bus.win_valid !== 1'b1 || bus.mem_sel_ind !== 9'h000 || bus.win_row !== exp_q[0].row
                      || bus.win_col !== exp_q[0].col || bus.win_data !== exp_q[0].data) begin
            n_err++;
            $display("FAIL bp_hold%0d got valid %b sel %h pos (%0d,%0d) required valid 1 sel 000 pos (%0d,%0d)",
                     i, bus.win_valid, bus.mem_sel_ind, bus.win_row, bus.win_col, exp_q[0].row, exp_q[0].col);
         end
      end
      bus.win_ready = 1'b1;
      wait_done("bp", 200);
      check_frame_end("bp", c0);
   endtask

   task automatic test_degenerate();
      int c0 = done_cnt;
      sel_seen = 1'b0;
      do_start(16'h0800, 2, 5, 1'b1);
      n_vec++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         n_err++;
         $display("FAIL degen_c1 got busy %b done %b required 1 0", busy, done);
      end
      @(posedge clk); #1;
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b1) begin
         n_err++;
         $display("FAIL degen_c2 got busy %b done %b required 0 1", busy, done);
      end
      @(posedge clk); #1;
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_err++;
         $display("FAIL degen_c3 got busy %b done %b required 0 0", busy, done);
      end
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (sel_seen !== 1'b0 || done_cnt != c0 + 1) begin
         n_err++;
         $display("FAIL degen_sel got sel_seen %b dones %0d required 0 1", sel_seen, done_cnt - c0);
      end
   endtask

   task automatic test_start_busy();
      int c0 = done_cnt;
      do_start(16'h0300, 4, 4, 1'b1);
      repeat (15) @(posedge clk);
      do_start(16'h7000, 5, 6, 1'b0);
      wait_done("busy_start", 400);
      repeat (20) @(posedge clk);
      #1;
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL busy_start_idle got busy %b required 0", busy);
      end
      check_frame_end("busy_start", c0);
   endtask

   task automatic test_reset_mid();
      int c0 = done_cnt;
      int n  = 0;
      arb_mode = 1;
      script_q.push_back(9'h01F);
      do_start(16'h0500, 3, 3, 1'b1);
      while (bus.mem_sel_ind !== 9'h1E0 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      n_vec++;
      if (bus.mem_sel_ind !== 9'h1E0) begin
         n_err++;
         $display("FAIL rstmid_partial got sel %h required 1e0", bus.mem_sel_ind);
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (bus.mem_sel_ind !== 9'h000 || bus.win_valid !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL rstmid_async got sel %h valid %b busy %b required 000 0 0", bus.mem_sel_ind, bus.win_valid, busy);
      end
      exp_q.delete();
      script_q.delete();
      arb_mode = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (busy !== 1'b0 || bus.mem_sel_ind !== 9'h000 || done_cnt != c0) begin
         n_err++;
         $display("FAIL rstmid_idle got busy %b sel %h dones %0d required 0 000 0", busy, bus.mem_sel_ind, done_cnt - c0);
      end
      do_start(16'h0500, 3, 3, 1'b1);
      wait_done("rstmid", 100);
      check_frame_end("rstmid", c0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got no finish required finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      start         = 1'b0;
      base_addr     = '0;
      img_width     = '0;
      img_height    = '0;
      bus.win_ready = 1'b1;
      test_reset();
      test_basic();
      test_out_of_order();
      test_backpressure();
      test_degenerate();
      test_start_busy();
      test_reset_mid();
      repeat (5) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/conv_window_fetch.md
Name: conv_window_fetch

Overview:
- Upstream requester for the 9-port memory arbiter. Walks a row-major 2-D feature map in memory and issues one read per 3x3 window tap, one tap per arbiter port.
- Gathers the nine returned words and presents each complete window to the convolution datapath over a valid/ready handshake.
- Read-only: never writes memory.

Parameters:
- ADDR_WIDTH, 16, width of the word address on each port.
- DATABUS_WIDTH, 32, width of each data word.
- DIM_WIDTH, 8, width of the runtime image width and height inputs.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- base_addr  input  ADDR_WIDTH  address of pixel (0,0); sampled on accepted start.
- img_width  input  DIM_WIDTH  pixels per row; sampled on accepted start.
- img_height  input  DIM_WIDTH  rows; sampled on accepted start.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse at frame end.
- mem_w_ind  output  9  per-port write flag; constant 0.
- mem_sel_ind  output  9  per-port request.
- mem_ready_ind  input  9  per-port completion from the arbiter.
- addr_bus_ind  output  ADDR_WIDTH x9  per-port address; tap k = dy*3+dx.
- data_bus_ind  input  DATABUS_WIDTH x9  per-port read data; never driven by this block.
- win_valid  output  1  window available.
- win_ready  input  1  consumer accepts the window.
- win_data  output  DATABUS_WIDTH x9  window taps, index k = dy*3+dx.
- win_row, win_col  output  DIM_WIDTH each  top-left coordinate of the presented window.

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, mem_sel_ind=0, mem_w_ind=0, addresses=0, win_valid=0, win_data=0, win_row=0, win_col=0.
- IDLE:
  - start=1 latches base, width and height, sets row=col=0, and sets busy=1 the next cycle.
  - If width<3 or height<3, go to DONE with no requests.
  - Otherwise go to ISSUE.
- ISSUE (one cycle):
  - Set addr[k] = base + (row+dy)*width + (col+dx), truncated mod 2^ADDR_WIDTH.
  - Clear captured mask; go to GATHER.
  - mem_sel_ind rises in the first GATHER cycle, i.e. the second cycle after the start pulse.
- GATHER:
  - Port k holds mem_sel_ind[k]=1 and a stable address until it samples mem_sel_ind[k]&mem_ready_ind[k]=1.
  - On that edge: capture data_bus_ind[k] into win_data[k], set mask[k], and drop mem_sel_ind[k] on the same edge (registered).
  - A port never re-raises sel while its mem_ready_ind[k] is still 1.
  - Completions arrive in any order and any number per cycle.
  - When the mask is all ones, go to OUT.
- OUT:
  - win_valid=1; win_data, win_row and win_col stay stable until win_valid&win_ready.
  - On that handshake, advance the position. Inside the advance, col+1 wraps to 0 past width-3, then row+1.
  - If the position was the last one (row=height-3, col=width-3), go to DONE; otherwise go to ISSUE.
  - win_valid drops the cycle after the handshake.
  - Latency per window = 1 (ISSUE) + arbiter service time + 1; no overlap between windows.
- DONE: done=1 for exactly one cycle, busy=0 from the same cycle, return to IDLE.
- start is ignored whenever state≠IDLE.
- mem_ready_ind[k] without sel[k] is ignored.
- Reset mid-operation:
  - All sel drop immediately (async) and win_valid clears.
  - The in-flight frame is abandoned and no done pulse is produced.
- Coordinate counters are DIM_WIDTH wide; address products use ADDR_WIDTH arithmetic.

Test Plan:
- Basic frame: width=4, height=4, base=0x0100, ready one port per cycle round-robin.
  - Exactly 4 windows at (0,0),(0,1),(1,0),(1,1).
  - First window addresses 0x100,0x101,0x102,0x104,0x105,0x106,0x108,0x109,0x10A.
  - win_data equals the memory model contents; done pulses once after the 4th handshake.
- Out-of-order completion: ready asserted for ports 8,0,4 simultaneously, then the rest in reverse order.
  - Each sel drops the cycle after its own ready.
  - win_valid only after all 9 captured; tap indices correct.
- Backpressure: hold win_ready=0 for 10 cycles while win_valid=1.
  - win_data and win_row/win_col stable; no new sel asserted; the window advances only on the handshake.
- Degenerate size: width=2, height=5.
  - No mem_sel_ind ever rises; done pulses in the second cycle after start; busy high for one cycle.
- Start while busy: second start pulse mid-frame with different base.
  - Ignored; addresses continue from the original base; a single done.
- Reset mid-GATHER: rst_n low with 5 of 9 taps captured.
  - mem_sel_ind=0 and win_valid=0 immediately; after release, state IDLE; a new start fetches window (0,0) correctly.
